// File: rtl/fft_result_unloader_pkg.sv
// Shared FFT configuration: frame geometry, sample width and unloader state encoding.
package fft_result_unloader_pkg;

    localparam int FFT_N         = 16;
    localparam int FFT_SIZE      = 4;
    localparam int FFT_BIT_WIDTH = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } unl_state_t;

endpackage

// File: rtl/fft_result_unloader_ram.sv
// Result buffer: one synchronous write port and one enabled, registered read port.
module result_ram
    import fft_result_unloader_pkg::*;
#(
    parameter int DATA_W = 2 * FFT_BIT_WIDTH,
    parameter int DEPTH  = FFT_N,
    parameter int ADDR_W = FFT_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // The read register doubles as the output data register, so it holds while rd_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_result_unloader.sv
// Collects one scrambled-order FFT frame into a buffer and streams it out in natural bin order.
module fft_result_unloader
    import fft_result_unloader_pkg::*;
#(
    parameter int bit_width = FFT_BIT_WIDTH,
    parameter int N         = FFT_N,
    parameter int SIZE      = FFT_SIZE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_i,
    input  logic signed [bit_width-1:0] Re_i,
    input  logic signed [bit_width-1:0] Im_i,
    input  logic [SIZE-1:0]             wr_ptr_i,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic signed [bit_width-1:0] Re_o,
    output logic signed [bit_width-1:0] Im_o,
    output logic [SIZE-1:0]             idx_o,
    output logic                        last_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        overflow_o
);

    localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);

    unl_state_t             state;
    logic [SIZE-1:0]        wr_cnt;
    logic [SIZE-1:0]        rd_idx_p0;
    logic                   rd_all_p0;
    logic                   rd_en_p0;
    logic                   beat_done;
    logic                   last_done;
    logic                   wr_en;
    logic [2*bit_width-1:0] rd_data_p1;

    assign beat_done = out_valid && out_ready;
    assign last_done = beat_done && last_o;
    // Read ahead whenever the output slot is empty or being consumed this cycle.
    assign rd_en_p0  = (state == ST_DRAIN) && !rd_all_p0 && (!out_valid || out_ready);
    assign wr_en     = valid_i && ((state != ST_DRAIN) || last_done);

    result_ram #(
        .DATA_W (2 * bit_width),
        .DEPTH  (N),
        .ADDR_W (SIZE)
    ) u_result_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_i),
        .wr_data ({Re_i, Im_i}),
        .rd_en   (rd_en_p0),
        .rd_addr (rd_idx_p0),
        .rd_data (rd_data_p1)
    );

    assign Re_o = rd_data_p1[2*bit_width-1:bit_width];
    assign Im_o = rd_data_p1[bit_width-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_cnt     <= '0;
            rd_idx_p0  <= '0;
            rd_all_p0  <= 1'b0;
            out_valid  <= 1'b0;
            idx_o      <= '0;
            last_o     <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            done_o <= last_done;
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        state  <= ST_COLLECT;
                        wr_cnt <= SIZE'(1);
                        busy_o <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (valid_i) begin
                        if (wr_cnt == LAST_IDX) begin
                            state     <= ST_DRAIN;
                            wr_cnt    <= '0;
                            rd_idx_p0 <= '0;
                            rd_all_p0 <= 1'b0;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (valid_i && !last_done)
                        overflow_o <= 1'b1;
                    if (rd_en_p0) begin
                        out_valid <= 1'b1;
                        idx_o     <= rd_idx_p0;
                        last_o    <= (rd_idx_p0 == LAST_IDX);
                        rd_idx_p0 <= rd_idx_p0 + 1'b1;
                        if (rd_idx_p0 == LAST_IDX)
                            rd_all_p0 <= 1'b1;
                    end else if (beat_done) begin
                        out_valid <= 1'b0;
                        last_o    <= 1'b0;
                    end
                    // A write landing on the final handshake opens the next frame directly.
                    if (last_done) begin
                        if (valid_i) begin
                            state  <= ST_COLLECT;
                            wr_cnt <= SIZE'(1);
                        end else begin
                            state  <= ST_IDLE;
                            wr_cnt <= '0;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_result_unloader.sv
// Self-checking bench: directed frame scenarios plus randomized frames against a bin-array model.
module tb_fft_result_unloader;

    localparam int BW = 24;
    localparam int N  = 16;
    localparam int SZ = 4;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 valid_i   = 1'b0;
    logic                 out_ready = 1'b0;
    logic signed [BW-1:0] Re_i      = '0;
    logic signed [BW-1:0] Im_i      = '0;
    logic [SZ-1:0]        wr_ptr_i  = '0;
    logic                 out_valid, last_o, busy_o, done_o, overflow_o;
    logic signed [BW-1:0] Re_o, Im_o;
    logic [SZ-1:0]        idx_o;

    int total = 0;
    int bad   = 0;

    logic signed [BW-1:0] mdl_re [N];
    logic signed [BW-1:0] mdl_im [N];
    int                   perm   [N];

    typedef struct {
        logic [SZ-1:0]        ptr;
        logic signed [BW-1:0] re;
        logic signed [BW-1:0] im;
        logic signed [BW-1:0] exp_re;
        logic signed [BW-1:0] exp_im;
    } vec_t;

    always #5 clk = ~clk;

    fft_result_unloader #(.bit_width(BW), .N(N), .SIZE(SZ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .Re_i       (Re_i),
        .Im_i       (Im_i),
        .wr_ptr_i   (wr_ptr_i),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .Re_o       (Re_o),
        .Im_o       (Im_o),
        .idx_o      (idx_o),
        .last_o     (last_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .overflow_o (overflow_o)
    );

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SZ-1:0] bitrev(input logic [SZ-1:0] v);
        for (int b = 0; b < SZ; b++) bitrev[b] = v[SZ-1-b];
    endfunction

    task automatic shuffle(input bit allow_repeat);
        int j, t;
        for (int i = 0; i < N; i++) perm[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        if (allow_repeat)
            for (int i = 0; i < N; i++) perm[i] = $urandom_range(0, N - 1);
    endtask

    task automatic do_write(input logic signed [BW-1:0] re, input logic signed [BW-1:0] im, input logic [SZ-1:0] ptr);
        valid_i = 1'b1; Re_i = re; Im_i = im; wr_ptr_i = ptr;
        step();
        valid_i = 1'b0;
        mdl_re[ptr] = re;
        mdl_im[ptr] = im;
    endtask

    task automatic write_perm(input int from, input int upto, input bit gaps);
        for (int i = from; i < upto; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            do_write(BW'($urandom), BW'($urandom), SZ'(perm[i]));
        end
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic drain(input int mode, input int inj_beat, input bit nx_en,
                         input logic signed [BW-1:0] nx_re, input logic signed [BW-1:0] nx_im,
                         input logic [SZ-1:0] nx_ptr, output int bubbles);
        logic signed [BW-1:0] er [N];
        logic signed [BW-1:0] ei [N];
        logic signed [BW-1:0] h_re, h_im;
        logic [SZ-1:0]        h_idx;
        int beats, cyc;
        bit held, started, injected;
        er = mdl_re; ei = mdl_im;
        beats = 0; cyc = 0; bubbles = 0; held = 0; started = 0; injected = 0;
        h_re = '0; h_im = '0; h_idx = '0;
        while (beats < N && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid) started = 1;
            else if (started) bubbles++;
            held = 0;
            if (out_valid && out_ready) begin
                check("beat_idx", idx_o, beats);
                check("beat_re", Re_o, er[beats]);
                check("beat_im", Im_o, ei[beats]);
                check("beat_last", last_o, beats == N - 1);
                if (beats == N - 1 && nx_en) begin
                    valid_i = 1'b1; Re_i = nx_re; Im_i = nx_im; wr_ptr_i = nx_ptr;
                end
                beats++;
            end else if (out_valid) begin
                held = 1; h_re = Re_o; h_im = Im_o; h_idx = idx_o;
            end
            if (inj_beat >= 0 && !injected && out_valid && idx_o == SZ'(inj_beat)) begin
                valid_i = 1'b1; Re_i = BW'($urandom); Im_i = BW'($urandom); wr_ptr_i = SZ'(12);
                injected = 1;
            end
            step();
            valid_i = 1'b0;
            cyc++;
            if (held) begin
                check("stall_valid", out_valid, 1);
                check("stall_re", Re_o, h_re);
                check("stall_im", Im_o, h_im);
                check("stall_idx", idx_o, h_idx);
            end
        end
        check("beat_count", beats, N);
    endtask

    task automatic check_end(input bit exp_busy);
        check("done_pulse", done_o, 1);
        check("valid_drop", out_valid, 0);
        check("busy_after", busy_o, exp_busy);
        step();
        check("done_single", done_o, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_re"}, Re_o, 0);
        check({tag, "_im"}, Im_o, 0);
        check({tag, "_idx"}, idx_o, 0);
        check({tag, "_last"}, last_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_ovf"}, overflow_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [N];
        int bub;
        logic signed [BW-1:0] vmin, vmax, nre, nim;
        vmin = {1'b1, {(BW-1){1'b0}}};
        vmax = {1'b0, {(BW-1){1'b1}}};

        rst_n = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Bit-reversed frame: sample k lands at bin bitrev(k), so bin j carries bitrev(j).
        for (int k = 0; k < N; k++) begin
            tbl[k].ptr    = bitrev(SZ'(k));
            tbl[k].re     = BW'(k);
            tbl[k].im     = -BW'(k);
            tbl[k].exp_re = BW'(bitrev(SZ'(k)));
            tbl[k].exp_im = -BW'(bitrev(SZ'(k)));
        end
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            do_write(tbl[k].re, tbl[k].im, tbl[k].ptr);
            if (k == 0) check("s1_busy_first", busy_o, 1);
        end
        check("s1_valid_t1", out_valid, 0);
        check("s1_busy_t1", busy_o, 1);
        step();
        for (int k = 0; k < N; k++) begin
            check("s1_valid", out_valid, 1);
            check("s1_idx", idx_o, k);
            check("s1_re", Re_o, tbl[k].exp_re);
            check("s1_im", Im_o, tbl[k].exp_im);
            check("s1_last", last_o, k == N - 1);
            step();
        end
        check_end(0);

        // Stalling ready pattern.
        shuffle(0);
        write_perm(0, N, 1);
        drain(1, -1, 0, '0, '0, '0, bub);
        check_end(0);

        // Write coincident with the last-beat handshake opens the next frame.
        shuffle(0);
        write_perm(0, N, 0);
        shuffle(0);
        nre = BW'($urandom); nim = BW'($urandom);
        drain(2, -1, 1, nre, nim, SZ'(perm[0]), bub);
        mdl_re[perm[0]] = nre; mdl_im[perm[0]] = nim;
        check_end(1);
        check("s4_ovf", overflow_o, 0);
        write_perm(1, N, 1);
        drain(0, -1, 0, '0, '0, '0, bub);
        check("s4_bubbles", bub, 0);
        check_end(0);
        check("s4_ovf_end", overflow_o, 0);

        // Write during drain is dropped and flagged.
        shuffle(0);
        write_perm(0, N, 0);
        drain(0, 5, 0, '0, '0, '0, bub);
        check_end(0);
        check("s3_ovf", overflow_o, 1);
        repeat (3) step();
        check("s3_ovf_sticky", overflow_o, 1);

        // Reset in the middle of collection.
        shuffle(0);
        write_perm(0, 7, 1);
        check("s5_busy_pre", busy_o, 1);
        check("s5_ovf_pre", overflow_o, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("s5_async");
        step();
        step();
        rst_n = 1'b1;
        shuffle(0);
        write_perm(0, N, 1);
        drain(2, -1, 0, '0, '0, '0, bub);
        check_end(0);

        // Full-scale extremes pass through bit-exact.
        shuffle(0);
        do_write(vmin, vmax, SZ'(perm[0]));
        write_perm(1, N, 0);
        drain(0, -1, 0, '0, '0, '0, bub);
        check("s6_bubbles", bub, 0);
        check_end(0);

        // Randomized frames, some with repeated addresses.
        for (int f = 0; f < 6; f++) begin
            shuffle(f % 2 == 1);
            write_perm(0, N, 1);
            drain(2, -1, 0, '0, '0, '0, bub);
            check_end(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_result_unloader.md
FFT_RESULT_UNLOADER -- requirements
Module: fft_result_unloader

Interface
REQ-001 SHALL have parameter bit_width, default 24: width of the signed Re/Im samples.
REQ-002 SHALL have parameter N, default 16: FFT frame length in points.
REQ-003 SHALL have parameter SIZE, default 4: address width, log2(N).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port valid_i  input  1  write strobe from the final FFT stage.
REQ-007 SHALL have port Re_i / Im_i  input  bit_width each  signed result sample.
REQ-008 SHALL have port wr_ptr_i  input  SIZE  buffer address of the sample (scrambled order).
REQ-009 SHALL have port out_ready  input  1  downstream accepts the current beat.
REQ-010 SHALL have port out_valid  output  1  Re_o/Im_o/idx_o hold a valid beat.
REQ-011 SHALL have port Re_o / Im_o  output  bit_width each  signed sample, natural order.
REQ-012 SHALL have port idx_o  output  SIZE  bin index of the current beat.
REQ-013 SHALL have port last_o  output  1  high with out_valid when idx_o == N-1.
REQ-014 SHALL have port busy_o  output  1  high when not IDLE.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse after the last beat is accepted.
REQ-016 SHALL have port overflow_o  output  1  sticky flag: a write was dropped.

Function
REQ-017 SHALL implement an N x (2*bit_width) buffer: synchronous write, registered read.
REQ-018 SHALL implement FSM states IDLE, COLLECT and DRAIN.
REQ-019 IDLE: on valid_i, SHALL write the sample and enter COLLECT with the write count at 1.
REQ-020 COLLECT: each valid_i SHALL write Re_i/Im_i at wr_ptr_i and increment the count; a repeated address SHALL still count.
REQ-021 COLLECT: the Nth write at cycle T SHALL move the FSM to DRAIN at T+1; the first out_valid (idx_o=0) SHALL appear at T+2.
REQ-022 DRAIN: beats SHALL be emitted in ascending order, idx_o = 0..N-1.
REQ-023 A beat transfers on out_valid && out_ready; Re_o/Im_o/idx_o/last_o SHALL stay stable while out_valid && !out_ready.
REQ-024 With out_ready held high, DRAIN SHALL emit N beats on N consecutive cycles (read-ahead/skid required; no bubbles).
REQ-025 out_ready is ignored when out_valid is low; out_valid SHALL NOT depend combinationally on out_ready.
REQ-026 On the handshake with last_o: done_o SHALL pulse the next cycle, out_valid SHALL drop, and the FSM SHALL return to IDLE.
REQ-027 valid_i in DRAIN SHALL NOT write the buffer and SHALL set overflow_o; the flag SHALL stay set until reset.
REQ-028 valid_i in the same cycle as the last-beat handshake SHALL be accepted as write 1 of the next frame (FSM goes to COLLECT, no overflow).
REQ-029 The write counter and read index SHALL wrap modulo N; no out-of-range addresses.
REQ-030 Data SHALL pass through unchanged: no scaling, rounding or sign change.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE and clear the counters.
REQ-032 rst_n low SHALL clear out_valid, Re_o, Im_o, idx_o, last_o, busy_o, done_o and overflow_o to 0.
REQ-033 Buffer contents are not reset; a frame interrupted by reset SHALL be discarded.

Structure
REQ-034 The state encoding and the N/SIZE/bit_width defaults SHALL come from the shared FFT config package.
REQ-035 The buffer SHALL be a sub-module named result_ram (dual-port: 1 write, 1 registered read).

Verification
REQ-036 Scenario: write N=16 samples with Re=k, Im=-k at wr_ptr=bitrev(k), out_ready=1 -> out_valid at T+2; 16 consecutive beats with idx 0..15; Re_o=bitrev-mapped values; last_o on idx 15; done_o one cycle later.
REQ-037 Scenario: out_ready toggles 1,0,0,1 during DRAIN -> outputs frozen on low cycles; exactly 16 beats; no duplicates or loss.
REQ-038 Scenario: valid_i pulse at DRAIN idx 5 -> overflow_o=1 and stays 1; drained data unchanged.
REQ-039 Scenario: valid_i coincident with the last-beat handshake -> busy_o stays 1, next frame needs only 15 further writes, overflow_o=0.
REQ-040 Scenario: rst_n low mid-COLLECT after 7 writes -> all outputs 0 immediately; next full 16-write frame drains correctly.
REQ-041 Scenario: Re_i=-2^(bit_width-1), Im_i=2^(bit_width-1)-1 -> values reproduced bit-exact on Re_o/Im_o.
